// File: rtl/cpu_prog_check_pkg.sv
// Shared types for the CPU program checker.
// The byte-mask typedef exists only when CPU_PROG_CHECK_MASK_EN is defined.
package cpu_prog_check_pkg;

    localparam int PKG_LINE_WIDTH = 128;
    localparam int LINE_BYTES     = PKG_LINE_WIDTH / 8;

    typedef logic [PKG_LINE_WIDTH-1:0] line_t;

`ifdef CPU_PROG_CHECK_MASK_EN
    typedef logic [LINE_BYTES-1:0] mask_t;
`endif

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } cpu_prog_check_state_e;

endpackage

// File: rtl/cpu_prog_checker_if.sv
// Memory read port used by the checker to fetch golden-compare lines.
// Handshake: the master raises mem_rd_req with a stable mem_rd_addr and holds both
// until the slave pulses mem_rd_ack; mem_rd_data is valid only in that ack cycle,
// and an ack seen while mem_rd_req is low carries no meaning.
interface cpu_prog_checker_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int LINE_WIDTH = 128
);
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_ack;
    logic [LINE_WIDTH-1:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_ack,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_ack,
        output mem_rd_data
    );
endinterface

// File: rtl/cpu_prog_line_compare.sv
// Combinational line comparator producing a single match bit.
// With CPU_PROG_CHECK_MASK_EN only bytes whose mask bit is set take part.
module cpu_prog_line_compare #(
    parameter int LINE_WIDTH = 128
) (
    input  logic [LINE_WIDTH-1:0]   data_i,
    input  logic [LINE_WIDTH-1:0]   expect_i,
`ifdef CPU_PROG_CHECK_MASK_EN
    input  logic [LINE_WIDTH/8-1:0] mask_i,
`endif
    output logic                    match_o
);

`ifdef CPU_PROG_CHECK_MASK_EN
    // An all-zero mask leaves match_o at its default of 1.
    always_comb begin
        match_o = 1'b1;
        for (int b = 0; b < LINE_WIDTH / 8; b++) begin
            if (mask_i[b] && (data_i[8*b +: 8] != expect_i[8*b +: 8])) begin
                match_o = 1'b0;
            end
        end
    end
`else
    assign match_o = (data_i == expect_i);
`endif

endmodule

// File: rtl/cpu_prog_checker.sv
// End-of-program monitor: counts run cycles, waits for offload, drains, then reads
// and compares golden lines. Optional byte masking via CPU_PROG_CHECK_MASK_EN.
module cpu_prog_checker
    import cpu_prog_check_pkg::*;
#(
    parameter int NUM_CHECKS     = 1,
    parameter int ADDR_WIDTH     = 28,
    parameter int LINE_WIDTH     = 128,
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter logic [ADDR_WIDTH-1:0] CHECK_ADDRS [NUM_CHECKS] = '{default: '0},
    parameter logic [LINE_WIDTH-1:0] CHECK_DATAS [NUM_CHECKS] = '{default: '0}
`ifdef CPU_PROG_CHECK_MASK_EN
    , parameter logic [LINE_WIDTH/8-1:0] CHECK_MASKS [NUM_CHECKS] = '{default: '1}
`endif
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                offload,
    cpu_prog_checker_if.master                  mem,
    output logic                                done,
    output logic                                pass,
    output logic                                timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]     fail_count,
    output logic [($clog2(NUM_CHECKS)|1)-1:0]   first_fail_idx,
    output logic [31:0]                         run_cycles,
    output cpu_prog_check_state_e               state
);

    localparam int FC_W  = $clog2(NUM_CHECKS + 1);
    localparam int FI_W  = $clog2(NUM_CHECKS) | 1;
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHECKS - 1);
    localparam logic [31:0]      TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LOAD = 32'(DRAIN_CYCLES);

    cpu_prog_check_state_e   state_q;
    logic [31:0]             run_q;
    logic [31:0]             drain_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    req_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    cmp_fail_q;
    logic [FC_W-1:0]         fail_q;
    logic [FI_W-1:0]         ffi_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic                    match;

    assign idx_nxt = idx_q + IDX_W'(1);

    cpu_prog_line_compare #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_cmp (
        .data_i   (mem.mem_rd_data),
        .expect_i (CHECK_DATAS[idx_q]),
`ifdef CPU_PROG_CHECK_MASK_EN
        .mask_i   (CHECK_MASKS[idx_q]),
`endif
        .match_o  (match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            run_q      <= '0;
            drain_q    <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            cmp_fail_q <= 1'b0;
            fail_q     <= '0;
            ffi_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (run_q != 32'hFFFF_FFFF) run_q <= run_q + 32'd1;
                    // Offload takes priority over a timeout landing in the same cycle.
                    if (offload) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end else if (TIMEOUT_CYCLES != 0 && run_q == TO_LAST) begin
                        state_q   <= ST_DONE;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= ST_REQ;
                        idx_q   <= '0;
                        req_q   <= 1'b1;
                        addr_q  <= CHECK_ADDRS[0];
                    end else begin
                        drain_q <= drain_q - 32'd1;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_rd_ack) begin
                        cmp_fail_q <= !match;
                        req_q      <= 1'b0;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The compare result registered in the ack cycle is folded in here.
                    if (cmp_fail_q) begin
                        fail_q <= fail_q + FC_W'(1);
                        if (fail_q == '0) ffi_q <= FI_W'(idx_q);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_q == '0) && !cmp_fail_q && !timeout_q;
                    end else begin
                        idx_q   <= idx_nxt;
                        req_q   <= 1'b1;
                        addr_q  <= CHECK_ADDRS[idx_nxt];
                        state_q <= ST_REQ;
                    end
                end
                ST_DONE: begin
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign mem.mem_rd_req  = req_q;
    assign mem.mem_rd_addr = addr_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign fail_count      = fail_q;
    assign first_fail_idx  = ffi_q;
    assign run_cycles      = run_q;
    assign state           = state_q;

endmodule

// File: tb/tb_cpu_prog_checker.sv
// Scoreboard bench for cpu_prog_checker: directed programs, a memory responder with
// configurable ack delay, and a monitor popping expected reads and results.
module tb_cpu_prog_checker;
  import cpu_prog_check_pkg::*;

  localparam int NC    = 3;
  localparam int AW    = 28;
  localparam int LW    = 128;
  localparam int RES_W = 39;

  localparam logic [AW-1:0] ADDRS [NC] = '{28'h0000010, 28'h0000020, 28'h0000035};
  localparam logic [LW-1:0] DATAS [NC] = '{128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                                           128'h0,
                                           128'h0000_0000_0000_0000_0000_0000_0000_CAFE};
`ifdef CPU_PROG_CHECK_MASK_EN
  localparam logic [LW/8-1:0] MASKS [NC] = '{16'hFFFF, 16'h000F, 16'hFFFF};
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic offload = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic                  done, pass, timeout;
  logic [1:0]            fail_count;
  logic [2:0]            first_fail_idx;
  logic [31:0]           run_cycles;
  cpu_prog_check_state_e state;

  cpu_prog_checker_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mem_if ();

  cpu_prog_checker #(
    .NUM_CHECKS     (NC),
    .ADDR_WIDTH     (AW),
    .LINE_WIDTH     (LW),
    .DRAIN_CYCLES   (5),
    .TIMEOUT_CYCLES (100),
    .CHECK_ADDRS    (ADDRS),
    .CHECK_DATAS    (DATAS)
`ifdef CPU_PROG_CHECK_MASK_EN
    , .CHECK_MASKS  (MASKS)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .offload        (offload),
    .mem            (mem_if),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .run_cycles     (run_cycles),
    .state          (state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [AW-1:0]    exp_addr_q[$];
  logic [RES_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int   ack_delay = 1;
  bit   spurious_en = 1'b0;
  int   rsp_idx = 0;
  int   wait_cnt = 0;
  logic [LW-1:0] rsp_data [NC];

  initial begin
    mem_if.mem_rd_ack  = 1'b0;
    mem_if.mem_rd_data = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        mem_if.mem_rd_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_if.mem_rd_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_if.mem_rd_ack  = 1'b1;
          mem_if.mem_rd_data = (rsp_idx < NC) ? rsp_data[rsp_idx] : {4{32'hBADC0DE5}};
          rsp_idx++;
          wait_cnt = 0;
        end else begin
          mem_if.mem_rd_ack  = 1'b0;
          mem_if.mem_rd_data = {4{32'hBADC0DE5}};
          wait_cnt++;
        end
      end else begin
        mem_if.mem_rd_ack  = spurious_en;
        mem_if.mem_rd_data = {4{32'h5EEDF00D}};
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic             done_seen = 1'b0;
  int               last_ack_cyc = 0;
  logic [RES_W-1:0] e;

  initial begin
    forever begin
      @(negedge clock);
      if (mem_if.mem_rd_req) begin
        chk("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          chk("rd_addr", 64'(mem_if.mem_rd_addr), 64'(exp_addr_q[0]));
          if (mem_if.mem_rd_ack) begin
            void'(exp_addr_q.pop_front());
            last_ack_cyc = cyc;
          end
        end
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("timeout", 64'(timeout), 64'(e[38]));
          chk("pass", 64'(pass), 64'(e[37]));
          chk("fail_count", 64'(fail_count), 64'(e[36:35]));
          chk("first_fail_idx", 64'(first_fail_idx), 64'(e[34:32]));
          chk("run_cycles", 64'(run_cycles), 64'(e[31:0]));
          chk("reads_left", 64'(exp_addr_q.size()), 64'd0);
          chk("req_in_done", 64'(mem_if.mem_rd_req), 64'd0);
          if (!e[38]) chk("ack_to_done", 64'(cyc - last_ack_cyc), 64'd2);
        end
      end else if (!done) begin
        done_seen = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    offload = 1'b0;
    @(posedge clock); #1;
    rsp_idx = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("done_within_budget", 64'(done), 64'd1);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_fail_count"}, 64'(fail_count), 64'd0);
    chk({tag, "_first_fail_idx"}, 64'(first_fail_idx), 64'd0);
    chk({tag, "_run_cycles"}, 64'(run_cycles), 64'd0);
    chk({tag, "_req"}, 64'(mem_if.mem_rd_req), 64'd0);
    chk({tag, "_state"}, 64'(state), 64'(ST_RUN));
  endtask

  task automatic run_prog(input bit skip_reset, input int off_at, input bit hold, input int delay,
                          input bit spur, input logic [LW-1:0] r0, input logic [LW-1:0] r1,
                          input logic [LW-1:0] r2, input logic [1:0] efc, input logic [2:0] effi,
                          input bit epass);
    if (!skip_reset) do_reset();
    ack_delay = delay;
    spurious_en = spur;
    rsp_data[0] = r0;
    rsp_data[1] = r1;
    rsp_data[2] = r2;
    for (int i = 0; i < NC; i++) exp_addr_q.push_back(ADDRS[i]);
    exp_q.push_back({1'b0, epass, efc, effi, 32'(off_at)});
    wait_cycles(off_at - 1);
    offload = 1'b1;
    if (!hold) begin
      wait_cycles(1);
      offload = 1'b0;
    end
    wait_done(2000);
    offload = 1'b0;
    spurious_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int n;
  initial begin
    do_reset();
    check_idle("reset");

    // Offload at cycle 40, all lines match, done stays high.
    run_prog(1'b0, 40, 1'b0, 1, 1'b0, DATAS[0], DATAS[1], DATAS[2], 2'd0, 3'd0, 1'b1);
    wait_cycles(3);
    chk("done_sticky", 64'(done), 64'd1);
    chk("state_done", 64'(state), 64'(ST_DONE));

    // Check 1 returns DEAD instead of 0; offload held high past RUN.
    run_prog(1'b0, 10, 1'b1, 1, 1'b0, DATAS[0], 128'hDEAD, DATAS[2], 2'd1, 3'd1, 1'b0);

    // Two mismatches: first_fail_idx keeps the first one.
    run_prog(1'b0, 15, 1'b0, 0, 1'b0, DATAS[0] ^ 128'h1, DATAS[1], 128'h0, 2'd2, 3'd0, 1'b0);

    // No offload: timeout at 100 cycles, no reads at all.
    do_reset();
    exp_q.push_back({1'b1, 1'b0, 2'd0, 3'd0, 32'd100});
    wait_done(300);
    chk("timeout_state", 64'(state), 64'(ST_DONE));

    // Slow acks with spurious acks whenever the request is low.
    run_prog(1'b0, 20, 1'b0, 7, 1'b1, DATAS[0], DATAS[1], DATAS[2], 2'd0, 3'd0, 1'b1);

    // Reset while the request for check 1 is outstanding.
    do_reset();
    ack_delay = 3;
    rsp_data[0] = DATAS[0];
    rsp_data[1] = DATAS[1];
    rsp_data[2] = DATAS[2];
    for (int i = 0; i < NC; i++) exp_addr_q.push_back(ADDRS[i]);
    wait_cycles(4);
    offload = 1'b1;
    wait_cycles(1);
    offload = 1'b0;
    n = 0;
    while (!(mem_if.mem_rd_req && mem_if.mem_rd_addr == ADDRS[1]) && n < 200) begin
      wait_cycles(1);
      n++;
    end
    chk("reached_check1", 64'(mem_if.mem_rd_req), 64'd1);
    reset = 1'b1;
    wait_cycles(1);
    check_idle("mid_reset");
    exp_addr_q.delete();
    wait_cycles(1);
    rsp_idx = 0;
    reset = 0;

    // Byte 8 differs on check 1; masked out only when masking is built in.
`ifdef CPU_PROG_CHECK_MASK_EN
    run_prog(1'b1, 12, 1'b0, 1, 1'b0, DATAS[0], 128'hAB << 64, DATAS[2], 2'd0, 3'd0, 1'b1);
`else
    run_prog(1'b1, 12, 1'b0, 1, 1'b0, DATAS[0], 128'hAB << 64, DATAS[2], 2'd1, 3'd1, 1'b0);
`endif

    chk("results_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
